// File: rtl/uart_adaptive_pkg.sv
// ---------------------------------------------------------------------------
// uart_adaptive_pkg
// Shared definitions for the adaptive UART configuration sequencer:
//   - host register addresses (min / max / mode / reserved)
//   - mode encoding written to the UART core
//   - sequencer FSM state enumeration
// ---------------------------------------------------------------------------
package uart_adaptive_pkg;

  localparam logic [1:0] ADDR_MIN  = 2'd0;
  localparam logic [1:0] ADDR_MAX  = 2'd1;
  localparam logic [1:0] ADDR_MODE = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  localparam logic MODE_NOR   = 1'b0;
  localparam logic MODE_8B10B = 1'b1;

  typedef enum logic [2:0] {
    BOOT_WAIT,
    BOOT_MIN,
    BOOT_MAX,
    BOOT_MODE,
    IDLE,
    EXEC,
    GAP
  } cfg_state_e;

endpackage

// File: rtl/uart_adaptive_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// uart_adaptive_cfg_ctrl
// Configuration sequencer for the adaptive UART core. After reset it pushes
// the default min/max divisors and mode to the core as a timed boot
// sequence, then serves a single host register port. Every update strobe to
// the core is followed by a guard gap so strobes are never back-to-back.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_cfg_req/wr/addr/wdata     host request (level, held until ack)
//   o_cfg_ack/err/rdata         host completion pulse, reject flag, read data
//   o_boot_done                 sticky: boot sequence finished
//   o_busy                      sequencer not idle
//   o_updata_*_vld/_data        update strobes and current values to the core
// ---------------------------------------------------------------------------
module uart_adaptive_cfg_ctrl #(
  parameter int BAUD_W   = 16,
  parameter int DEF_MIN  = 54,
  parameter int DEF_MAX  = 5208,
  parameter int DEF_MODE = 0,
  parameter int BOOT_DLY = 16,
  parameter int GAP_CYC  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_req,
  input  logic              i_cfg_wr,
  input  logic [1:0]        i_cfg_addr,
  input  logic [BAUD_W-1:0] i_cfg_wdata,
  output logic              o_cfg_ack,
  output logic              o_cfg_err,
  output logic [BAUD_W-1:0] o_cfg_rdata,
  output logic              o_boot_done,
  output logic              o_busy,
  output logic              o_updata_min_b_vld,
  output logic [BAUD_W-1:0] o_updata_min_b_data,
  output logic              o_updata_max_b_vld,
  output logic [BAUD_W-1:0] o_updata_max_b_data,
  output logic              o_updata_8b10_or_nor_vld,
  output logic              o_updata_8b10_or_nor_data
);

  import uart_adaptive_pkg::*;

  // One down-counter is shared by the boot wait and every guard gap.
  localparam int CNT_MAX = (BOOT_DLY > GAP_CYC) ? BOOT_DLY : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cfg_state_e        state_q, state_d;
  cfg_state_e        ret_q, ret_d;        // state to resume after a GAP
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Shadow registers: these are the data outputs seen by the core.
  logic [BAUD_W-1:0] min_q;
  logic [BAUD_W-1:0] max_q;
  logic              mode_q;

  // Result of the host access sampled in IDLE, presented during EXEC.
  logic              err_q;
  logic              upd_q;
  logic [1:0]        upd_addr_q;
  logic [BAUD_W-1:0] rdata_q;
  logic              boot_done_q;

  logic              req_go;
  logic              acc_ok;
  logic [BAUD_W-1:0] rd_val;

  assign req_go = (state_q == IDLE) && i_cfg_req;

  // Access decode. Range checks use the current shadows so that the
  // invariant 0 < min <= max can never be broken by a single write.
  always_comb begin
    acc_ok = 1'b0;
    rd_val = '0;
    case (i_cfg_addr)
      ADDR_MIN: begin
        acc_ok = !i_cfg_wr || ((i_cfg_wdata != '0) && (i_cfg_wdata <= max_q));
        rd_val = min_q;
      end
      ADDR_MAX: begin
        acc_ok = !i_cfg_wr || ((i_cfg_wdata != '0) && (i_cfg_wdata >= min_q));
        rd_val = max_q;
      end
      ADDR_MODE: begin
        acc_ok = 1'b1;
        rd_val = {{(BAUD_W-1){1'b0}}, mode_q};
      end
      default: begin
        acc_ok = 1'b0;
        rd_val = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= BOOT_WAIT;
      ret_q   <= BOOT_MAX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT_WAIT: begin
        if (cnt_q == CNT_W'(BOOT_DLY - 1)) begin
          state_d = BOOT_MIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BOOT_MIN: begin
        state_d = GAP;
        ret_d   = BOOT_MAX;
        cnt_d   = '0;
      end
      BOOT_MAX: begin
        state_d = GAP;
        ret_d   = BOOT_MODE;
        cnt_d   = '0;
      end
      BOOT_MODE: begin
        state_d = GAP;
        ret_d   = IDLE;
        cnt_d   = '0;
      end
      IDLE: begin
        if (i_cfg_req) state_d = EXEC;
      end
      EXEC: begin
        // Only an accepted write strobed the core, so only it needs a gap.
        if (upd_q) begin
          state_d = GAP;
          ret_d   = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = ret_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = BOOT_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadows and host result registers. The shadow is written at the end of
  // the IDLE sampling cycle so the new value is on the data output exactly
  // in the EXEC cycle, together with its strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      min_q       <= BAUD_W'(DEF_MIN);
      max_q       <= BAUD_W'(DEF_MAX);
      mode_q      <= 1'(DEF_MODE);
      err_q       <= 1'b0;
      upd_q       <= 1'b0;
      upd_addr_q  <= ADDR_MIN;
      rdata_q     <= '0;
      boot_done_q <= 1'b0;
    end else begin
      boot_done_q <= boot_done_q | (state_d == IDLE);
      if (req_go) begin
        err_q      <= !acc_ok;
        upd_q      <= i_cfg_wr && acc_ok;
        upd_addr_q <= i_cfg_addr;
        if (!i_cfg_wr) rdata_q <= acc_ok ? rd_val : '0;
        if (i_cfg_wr && acc_ok) begin
          case (i_cfg_addr)
            ADDR_MIN:  min_q  <= i_cfg_wdata;
            ADDR_MAX:  max_q  <= i_cfg_wdata;
            ADDR_MODE: mode_q <= i_cfg_wdata[0] ? MODE_8B10B : MODE_NOR;
            default:   ;
          endcase
        end
      end
    end
  end

  // Output logic: strobes are decoded from the state, so at most one is
  // high per cycle and each lasts exactly one cycle.
  always_comb begin
    o_cfg_ack                 = (state_q == EXEC);
    o_cfg_err                 = (state_q == EXEC) && err_q;
    o_cfg_rdata               = rdata_q;
    o_boot_done               = boot_done_q;
    o_busy                    = (state_q != IDLE);
    o_updata_min_b_vld        = (state_q == BOOT_MIN) ||
                                ((state_q == EXEC) && upd_q && (upd_addr_q == ADDR_MIN));
    o_updata_max_b_vld        = (state_q == BOOT_MAX) ||
                                ((state_q == EXEC) && upd_q && (upd_addr_q == ADDR_MAX));
    o_updata_8b10_or_nor_vld  = (state_q == BOOT_MODE) ||
                                ((state_q == EXEC) && upd_q && (upd_addr_q == ADDR_MODE));
    o_updata_min_b_data       = min_q;
    o_updata_max_b_data       = max_q;
    o_updata_8b10_or_nor_data = mode_q;
  end

endmodule

// File: tb/tb_uart_adaptive_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_adaptive_cfg_ctrl
// Directed bench: cycle-exact boot check (with a host request pending during
// boot), a table of host transactions, and a reset asserted inside a guard
// gap followed by a full boot replay.
// ---------------------------------------------------------------------------
module tb_uart_adaptive_cfg_ctrl;

  localparam int BAUD_W   = 16;
  localparam int DEF_MIN  = 54;
  localparam int DEF_MAX  = 5208;
  localparam int DEF_MODE = 0;
  localparam int BOOT_DLY = 16;
  localparam int GAP_CYC  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_req;
  logic              cfg_wr;
  logic [1:0]        cfg_addr;
  logic [BAUD_W-1:0] cfg_wdata;
  logic              cfg_ack;
  logic              cfg_err;
  logic [BAUD_W-1:0] cfg_rdata;
  logic              boot_done;
  logic              busy;
  logic              min_vld;
  logic [BAUD_W-1:0] min_data;
  logic              max_vld;
  logic [BAUD_W-1:0] max_data;
  logic              mode_vld;
  logic              mode_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_adaptive_cfg_ctrl #(
    .BAUD_W  (BAUD_W),
    .DEF_MIN (DEF_MIN),
    .DEF_MAX (DEF_MAX),
    .DEF_MODE(DEF_MODE),
    .BOOT_DLY(BOOT_DLY),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_cfg_req                (cfg_req),
    .i_cfg_wr                 (cfg_wr),
    .i_cfg_addr               (cfg_addr),
    .i_cfg_wdata              (cfg_wdata),
    .o_cfg_ack                (cfg_ack),
    .o_cfg_err                (cfg_err),
    .o_cfg_rdata              (cfg_rdata),
    .o_boot_done              (boot_done),
    .o_busy                   (busy),
    .o_updata_min_b_vld       (min_vld),
    .o_updata_min_b_data      (min_data),
    .o_updata_max_b_vld       (max_vld),
    .o_updata_max_b_data      (max_data),
    .o_updata_8b10_or_nor_vld (mode_vld),
    .o_updata_8b10_or_nor_data(mode_data)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;  // checked only for accepted reads
    logic [1:0]  exp_sel;    // 0 none, 1 min, 2 max, 3 mode strobe
    logic [15:0] exp_data;   // value on the strobed data output
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at the negedge of cycle 0 (first cycle with reset released).
  // Flags vector: {ack, err, min_vld, max_vld, mode_vld, boot_done, busy}.
  task automatic run_boot(input bit with_req);
    logic [6:0]  exp_f;
    logic [6:0]  act_f;
    logic [15:0] exp_min;
    for (int c = 0; c <= 38; c++) begin
      exp_f[6] = with_req && (c == 32);
      exp_f[5] = 1'b0;
      exp_f[4] = (c == BOOT_DLY) || (with_req && (c == 32));
      exp_f[3] = (c == BOOT_DLY + GAP_CYC + 1);
      exp_f[2] = (c == BOOT_DLY + 2 * (GAP_CYC + 1));
      exp_f[1] = (c >= BOOT_DLY + 3 * (GAP_CYC + 1));
      exp_f[0] = (c < 31) || (with_req && (c >= 32) && (c <= 32 + GAP_CYC));
      exp_min  = (with_req && (c >= 32)) ? 16'd100 : 16'(DEF_MIN);
      act_f    = {cfg_ack, cfg_err, min_vld, max_vld, mode_vld, boot_done, busy};
      check($sformatf("boot c%0d flags", c), 32'(act_f), 32'(exp_f));
      check($sformatf("boot c%0d data", c), {min_data, max_data[14:0], mode_data},
            {exp_min, 15'(DEF_MAX), 1'(DEF_MODE)});
      if (c == 0) check("reset rdata", 32'(cfg_rdata), 32'd0);
      if (with_req && (c == 2)) begin
        cfg_req   = 1'b1;
        cfg_wr    = 1'b1;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'd100;
      end
      if (with_req && (c == 32)) cfg_req = 1'b0;
      @(negedge clk);
    end
    $display("boot with_req=%0d done: boot_done=%0d min=%0d max=%0d mode=%0d",
             with_req, boot_done, min_data, max_data, mode_data);
  endtask

  // Issues one request from IDLE and checks ack latency, result, strobe,
  // and the number of busy cycles that follow the ack.
  task automatic do_txn(input int idx, input vec_t v);
    logic [2:0]  exp_vld;
    logic [15:0] act_data;
    int          lat;
    int          nb;
    bit          extra;
    cfg_req   = 1'b1;
    cfg_wr    = v.wr;
    cfg_addr  = v.addr;
    cfg_wdata = v.wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cfg_ack && (lat < 8));
    check($sformatf("t%0d ack latency", idx), 32'(lat), 32'd1);
    check($sformatf("t%0d err", idx), 32'(cfg_err), 32'(v.exp_err));
    if (!v.wr && !v.exp_err)
      check($sformatf("t%0d rdata", idx), 32'(cfg_rdata), 32'(v.exp_rdata));
    case (v.exp_sel)
      2'd1:    begin exp_vld = 3'b100; act_data = min_data; end
      2'd2:    begin exp_vld = 3'b010; act_data = max_data; end
      2'd3:    begin exp_vld = 3'b001; act_data = {15'd0, mode_data}; end
      default: begin exp_vld = 3'b000; act_data = 16'd0; end
    endcase
    check($sformatf("t%0d vld", idx), 32'({min_vld, max_vld, mode_vld}), 32'(exp_vld));
    if (v.exp_sel != 2'd0)
      check($sformatf("t%0d upd data", idx), 32'(act_data), 32'(v.exp_data));
    $display("txn %0d wr=%0d addr=%0d wdata=0x%04h -> err=%0d rdata=0x%04h vld=%03b",
             idx, v.wr, v.addr, v.wdata, cfg_err, cfg_rdata, {min_vld, max_vld, mode_vld});
    cfg_req = 1'b0;
    nb      = 0;
    extra   = 1'b0;
    @(negedge clk);
    while (busy && (nb < 20)) begin
      extra |= cfg_ack | min_vld | max_vld | mode_vld;
      nb++;
      @(negedge clk);
    end
    check($sformatf("t%0d gap cycles", idx), 32'(nb),
          (v.exp_sel != 2'd0) ? 32'(GAP_CYC) : 32'd0);
    check($sformatf("t%0d quiet gap", idx), 32'(extra), 32'd0);
  endtask

  initial begin
    // Shadows after the pending boot-time write: min=100 max=5208 mode=0
    tbl[0]  = '{1'b1, 2'd0, 16'd6000,  1'b1, 16'd0,    2'd0, 16'd0};
    tbl[1]  = '{1'b0, 2'd0, 16'd0,     1'b0, 16'd100,  2'd0, 16'd0};
    tbl[2]  = '{1'b1, 2'd1, 16'd0,     1'b1, 16'd0,    2'd0, 16'd0};
    tbl[3]  = '{1'b1, 2'd1, 16'd100,   1'b0, 16'd0,    2'd2, 16'd100};
    tbl[4]  = '{1'b1, 2'd0, 16'd100,   1'b0, 16'd0,    2'd1, 16'd100};
    tbl[5]  = '{1'b1, 2'd0, 16'd101,   1'b1, 16'd0,    2'd0, 16'd0};
    tbl[6]  = '{1'b1, 2'd1, 16'd99,    1'b1, 16'd0,    2'd0, 16'd0};
    tbl[7]  = '{1'b1, 2'd1, 16'd100,   1'b0, 16'd0,    2'd2, 16'd100};
    tbl[8]  = '{1'b1, 2'd0, 16'd100,   1'b0, 16'd0,    2'd1, 16'd100};
    tbl[9]  = '{1'b1, 2'd2, 16'hFFFF,  1'b0, 16'd0,    2'd3, 16'd1};
    tbl[10] = '{1'b0, 2'd2, 16'd0,     1'b0, 16'd1,    2'd0, 16'd0};
    tbl[11] = '{1'b0, 2'd3, 16'd0,     1'b1, 16'd0,    2'd0, 16'd0};
    tbl[12] = '{1'b1, 2'd3, 16'h1234,  1'b1, 16'd0,    2'd0, 16'd0};
    tbl[13] = '{1'b0, 2'd1, 16'd0,     1'b0, 16'd100,  2'd0, 16'd0};
    tbl[14] = '{1'b1, 2'd0, 16'd0,     1'b1, 16'd0,    2'd0, 16'd0};
    tbl[15] = '{1'b1, 2'd1, 16'd5208,  1'b0, 16'd0,    2'd2, 16'd5208};
    tbl[16] = '{1'b1, 2'd0, 16'd54,    1'b0, 16'd0,    2'd1, 16'd54};
    tbl[17] = '{1'b0, 2'd0, 16'd0,     1'b0, 16'd54,   2'd0, 16'd0};
    tbl[18] = '{1'b1, 2'd2, 16'd2,     1'b0, 16'd0,    2'd3, 16'd0};
    tbl[19] = '{1'b0, 2'd2, 16'd0,     1'b0, 16'd0,    2'd0, 16'd0};
    tbl[20] = '{1'b0, 2'd1, 16'd0,     1'b0, 16'd5208, 2'd0, 16'd0};

    rst_n     = 1'b0;
    cfg_req   = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Boot with a write request held from cycle 2
    run_boot(1'b1);

    for (int i = 0; i < 21; i++) do_txn(i, tbl[i]);

    // Reset inside the guard gap of an accepted write
    cfg_req   = 1'b1;
    cfg_wr    = 1'b1;
    cfg_addr  = 2'd0;
    cfg_wdata = 16'd60;
    @(negedge clk);
    check("midgap ack+vld", 32'({cfg_ack, min_vld}), 32'b11);
    check("midgap data", 32'(min_data), 32'd60);
    cfg_req = 1'b0;
    @(negedge clk);
    check("midgap busy", 32'(busy), 32'd1);
    $display("txn midgap write min=60 ack seen, reset asserted in gap");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_boot(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
